// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a byte stream with a 16-bit big-endian
// word-count header and writes big-endian 32-bit words, holding the core in reset meanwhile.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              cpu_hold_o,
  output logic [15:0]       word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_BYTE,
    S_WRITE
  } state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              cpu_hold_q;
  logic [15:0]       word_count_q;
  logic [1:0]        byte_cnt_q;

  logic              acc_d;
  logic [15:0]       len_d;
  logic              len_zero_d;
  logic              len_big_d;
  logic              last_d;

  assign acc_d      = in_valid_i && in_ready_q;
  // Full header as it will stand once the low byte lands this edge.
  assign len_d      = {word_count_q[15:8], in_data_i};
  assign len_zero_d = (len_d == 16'd0);
  assign len_big_d  = (32'(len_d) > 32'(DEPTH));
  assign last_d     = (32'(mem_addr_q) == (32'(word_count_q) - 32'd1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_hold_q   <= 1'b1;
      word_count_q <= '0;
      byte_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_LEN_HI;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            byte_cnt_q <= '0;
            busy_q     <= 1'b1;
            cpu_hold_q <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (acc_d) begin
            word_count_q[15:8] <= in_data_i;
            state_q            <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (acc_d) begin
            word_count_q[7:0] <= in_data_i;
            if (len_zero_d) begin
              state_q    <= S_IDLE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
              busy_q     <= 1'b0;
            end else if (len_big_d) begin
              // Oversized image: refuse it and keep the core parked.
              state_q    <= S_IDLE;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              state_q <= S_BYTE;
            end
          end
        end
        S_BYTE: begin
          if (acc_d) begin
            // Byte k lands at bit offset 8*(3-k), i.e. MSB-first.
            mem_wdata_q[{~byte_cnt_q, 3'b000} +: 8] <= in_data_i;
            if (byte_cnt_q == 2'd3) begin
              byte_cnt_q <= '0;
              state_q    <= S_WRITE;
              in_ready_q <= 1'b0;
              mem_we_q   <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end
        S_WRITE: begin
          mem_we_q <= 1'b0;
          if (last_d) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
            state_q    <= S_BYTE;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign cpu_hold_o   = cpu_hold_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed timing sequences, a vector table and random loads
// checked against an image-level model of the expected writes and status flags.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, mem_we, busy, done, err, cpu_hold;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [15:0]       word_count;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_data_i(in_data),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .busy_o(busy),
    .done_o(done), .err_o(err), .cpu_hold_o(cpu_hold), .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int st_cyc = 0, done_cyc = -1;
  logic done_d = 1'b0;
  logic [7:0]  src_q[$];
  logic [7:0]  img_q[$];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  // Write log and done-rise timestamp, both sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (done && !done_d) done_cyc = cyc;
    done_d = done;
  end

  typedef struct {
    logic [15:0] hdr;
    int          rnd;
    bit          inc;
    bit          e_done;
    bit          e_err;
    bit          e_hold;
    int          e_nwr;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_cyc = -1;
  endtask

  task automatic do_start();
    start = 1'b1;
    sync();
    start = 1'b0;
    st_cyc = cyc;
  endtask

  // Feed src_q under the handshake; optional random idles, a fixed gap, and start held high.
  task automatic drain(input int rnd, input int gap_after, input int gap_len, input bit hold_start);
    int popped = 0, idle = 0, n = 0;
    bit acc;
    while (src_q.size() > 0) begin
      if (n++ > 20000) begin
        checks++; errors++;
        $display("FAIL drain_timeout actual=%0d bytes left expected=0", src_q.size());
        src_q.delete();
        break;
      end
      if (popped == gap_after && idle < gap_len) begin
        in_valid = 1'b0;
        idle++;
      end else begin
        in_valid = (rnd == 0) || ($urandom_range(0, 3) != 0);
      end
      in_data = src_q[0];
      start   = hold_start;
      @(negedge clk);
      acc = in_valid && in_ready;
      sync();
      if (acc) begin
        void'(src_q.pop_front());
        popped++;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({p, "_mem_we"},   32'(mem_we),   32'd0);
    chk({p, "_addr"},     32'(mem_addr), 32'd0);
    chk({p, "_wdata"},    mem_wdata,     32'd0);
    chk({p, "_busy"},     32'(busy),     32'd0);
    chk({p, "_done"},     32'(done),     32'd0);
    chk({p, "_err"},      32'(err),      32'd0);
    chk({p, "_hold"},     32'(cpu_hold), 32'd1);
    chk({p, "_wc"},       32'(word_count), 32'd0);
  endtask

  // Model: image of N words, words are big-endian groups of img_q, written to addr 0..N-1.
  task automatic chk_image(input string p, input logic [15:0] hdr, input int e_nwr);
    int n;
    logic [31:0] w;
    n = (hdr == 16'd0 || int'(hdr) > DEPTH) ? 0 : int'(hdr);
    chk({p, "_nwr_model"}, 32'(wr_addr_q.size()), 32'(n));
    chk({p, "_nwr_table"}, 32'(wr_addr_q.size()), 32'(e_nwr));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      w = {img_q[4*i], img_q[4*i+1], img_q[4*i+2], img_q[4*i+3]};
      chk($sformatf("%s_addr%0d", p, i), 32'(wr_addr_q[i]), 32'(i));
      chk($sformatf("%s_data%0d", p, i), wr_data_q[i], w);
    end
  endtask

  task automatic run_vec(input string p, input vec_t v);
    int n;
    logic [7:0] b;
    clear_log();
    img_q.delete();
    src_q = {v.hdr[15:8], v.hdr[7:0]};
    n = (v.hdr == 16'd0 || int'(v.hdr) > DEPTH) ? 0 : int'(v.hdr);
    for (int i = 0; i < 4*n; i++) begin
      b = v.inc ? 8'(i) : 8'($urandom);
      img_q.push_back(b);
      src_q.push_back(b);
    end
    do_start();
    drain(v.rnd, -1, 0, 1'b0);
    if (n == 0) begin
      // Header-only outcome must be visible the cycle right after LEN_LO.
      @(negedge clk);
      chk({p, "_hdr_done"}, 32'(done), 32'(v.e_done));
      chk({p, "_hdr_err"},  32'(err),  32'(v.e_err));
    end else begin
      wait_idle();
    end
    repeat (3) @(negedge clk);
    chk({p, "_done"},     32'(done),     32'(v.e_done));
    chk({p, "_err"},      32'(err),      32'(v.e_err));
    chk({p, "_hold"},     32'(cpu_hold), 32'(v.e_hold));
    chk({p, "_busy"},     32'(busy),     32'd0);
    chk({p, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({p, "_wc"},       32'(word_count), 32'(v.hdr));
    chk_image(p, v.hdr, v.e_nwr);
    sync();
  endtask

  task automatic load_small_image();
    clear_log();
    img_q = {8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
    src_q = {8'h00, 8'h02};
    foreach (img_q[i]) src_q.push_back(img_q[i]);
  endtask

  task automatic chk_small(input string p, input int lat);
    chk({p, "_nwr"}, 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() >= 2) begin
      chk({p, "_a0"}, 32'(wr_addr_q[0]), 32'd0);
      chk({p, "_d0"}, wr_data_q[0], 32'h20080005);
      chk({p, "_a1"}, 32'(wr_addr_q[1]), 32'd1);
      chk({p, "_d1"}, wr_data_q[1], 32'h8C090000);
      chk({p, "_lat0"}, 32'(wr_cyc_q[0] - st_cyc), 32'(lat));
      chk({p, "_lat1"}, 32'(wr_cyc_q[1] - st_cyc), 32'(lat + 5));
    end
    chk({p, "_done_at"}, 32'(done_cyc - st_cyc), 32'(lat + 6));
    chk({p, "_done"}, 32'(done), 32'd1);
    chk({p, "_hold"}, 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   n;
    vecs[0] = '{16'h0002, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[1] = '{16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[2] = '{16'h0101, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[3] = '{16'h0001, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[4] = '{16'h0100, 0, 1'b1, 1'b1, 1'b0, 1'b0, 256};
    vecs[5] = '{16'hFFFF, 1, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[6] = '{16'h00FF, 1, 1'b0, 1'b1, 1'b0, 1'b0, 255};
    vecs[7] = '{16'h0200, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    sync();
    rst_n = 1'b1;
    sync();

    // Back-to-back image: first write 6 cycles after start is sampled.
    load_small_image();
    do_start();
    drain(0, -1, 0, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    chk_small("nogap", 6);
    sync();

    // 3-cycle gap between bytes 2 and 3 of word 0, with start held high throughout.
    load_small_image();
    do_start();
    drain(0, 4, 3, 1'b1);
    wait_idle();
    repeat (2) @(negedge clk);
    chk_small("gap", 9);
    sync();

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset after 2 bytes of word 1: word 1 is never written.
    load_small_image();
    repeat (2) void'(src_q.pop_back());
    do_start();
    drain(0, -1, 0, 1'b0);
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    repeat (8) @(negedge clk);
    chk("midrst_nwr", 32'(wr_addr_q.size()), 32'd1);
    sync();
    run_vec("reload", '{16'h0003, 1, 1'b0, 1'b1, 1'b0, 1'b0, 3});

    // Random headers, flags predicted from the header rules.
    for (int k = 0; k < 6; k++) begin
      v.hdr = 16'($urandom_range(0, 300));
      if (k == 0) v.hdr = 16'd257;
      n = int'(v.hdr);
      v.rnd = 1;
      v.inc = 1'b0;
      v.e_err  = (n > DEPTH);
      v.e_done = !v.e_err;
      v.e_hold = v.e_err;
      v.e_nwr  = v.e_err ? 0 : n;
      run_vec($sformatf("rnd%0d", k), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
